// File: rtl/ramsdp_clr_if.sv
// Write/read port bundle for ramsdp_clr.
// The master side drives writes and reads; the slave side returns read data and busy.
interface ramsdp_clr_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8,
  parameter int unsigned BW = 8
);
  localparam int unsigned NB = DW / BW;

  logic          busy;
  logic          we;
  logic [NB-1:0] wmask;
  logic [AW-1:0] waddr;
  logic [DW-1:0] din;
  logic          re;
  logic [AW-1:0] raddr;
  logic [DW-1:0] dout;
  logic          dvalid;

  modport master (
    input  busy, dout, dvalid,
    output we, wmask, waddr, din, re, raddr
  );

  modport slave (
    output busy, dout, dvalid,
    input  we, wmask, waddr, din, re, raddr
  );
endinterface

// File: rtl/ramsdp_clr.sv
// Simple dual-port RAM with byte-lane write mask, registered read and a clear-after-reset sweep.
// Define RAMSDP_CLR_OUTREG_EN to add a second output stage (read latency 2).
module ramsdp_clr #(
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 8,
  parameter int unsigned BW       = 8,
  parameter int unsigned RDW_MODE = 0
) (
  input logic          clk,
  input logic          rst,
  ramsdp_clr_if.slave  bus
);
  localparam int unsigned NB    = DW / BW;
  localparam int unsigned Depth = 2 ** AW;

  typedef enum logic {StClear, StReady} state_e;

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;
  logic [DW-1:0] mem [Depth];
  logic [DW-1:0] old_word;
  logic [DW-1:0] merged_word;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] rdata_q;
  logic          rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StClear: begin
          cnt_q <= cnt_q + AW'(1);
          // Terminal detect on all-ones; the counter wrap afterwards is harmless in StReady.
          if (&cnt_q) begin
            state_q <= StReady;
            busy_q  <= 1'b0;
          end
        end
        StReady: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StClear) begin
        mem[cnt_q] <= '0;
      end else if (bus.we) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.wmask[i]) mem[bus.waddr][i*BW +: BW] <= bus.din[i*BW +: BW];
        end
      end
    end
  end

  // Same-address forwarding of the masked lanes for the new-data policy.
  always_comb begin
    old_word    = mem[bus.raddr];
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (bus.we && (bus.waddr == bus.raddr) && bus.wmask[i]) begin
        merged_word[i*BW +: BW] = bus.din[i*BW +: BW];
      end
    end
    rd_word = (RDW_MODE == 1) ? merged_word : old_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (busy_q) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= bus.re;
      if (bus.re) rdata_q <= rd_word;
    end
  end

`ifdef RAMSDP_CLR_OUTREG_EN
  logic [DW-1:0] dout2_q;
  logic          dvalid2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout2_q   <= '0;
      dvalid2_q <= 1'b0;
    end else begin
      dout2_q   <= rdata_q;
      dvalid2_q <= rvalid_q & ~busy_q;
    end
  end

  assign bus.dout   = dout2_q;
  assign bus.dvalid = dvalid2_q;
`else
  assign bus.dout   = rdata_q;
  assign bus.dvalid = rvalid_q;
`endif

  assign bus.busy = busy_q;

endmodule

// File: tb/tb_ramsdp_clr.sv
// Scoreboard bench for ramsdp_clr; adapts its expected latency to RAMSDP_CLR_OUTREG_EN.
module tb_ramsdp_clr;
  parameter int RDW_MODE = 0;
`ifdef RAMSDP_CLR_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic        v;
    logic [15:0] d;
  } exp_t;

  typedef struct packed {
    logic        w;
    logic [1:0]  m;
    logic [7:0]  wa;
    logic [15:0] d;
    logic        r;
    logic [7:0]  ra;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [15:0] mem_m [256];
  logic [15:0] last_d;
  exp_t        sb [$];

  ramsdp_clr_if #(.DW(16), .AW(8), .BW(8)) bus ();

  ramsdp_clr #(.DW(16), .AW(8), .BW(8), .RDW_MODE(RDW_MODE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic reset_model();
    for (int a = 0; a < 256; a++) mem_m[a] = 16'h0000;
    last_d = 16'h0000;
    sb.delete();
  endtask

  task automatic set_idle();
    bus.we = 1'b0; bus.wmask = 2'b00; bus.waddr = 8'h00; bus.din = 16'h0000;
    bus.re = 1'b0; bus.raddr = 8'h00;
  endtask

  // One READY-state cycle: drive, then update the model and push the expected output.
  task automatic drive(input op_t op);
    logic [15:0] old_w, mrg, rd;
    @(negedge clk);
    bus.we = op.w; bus.wmask = op.m; bus.waddr = op.wa; bus.din = op.d;
    bus.re = op.r; bus.raddr = op.ra;
    @(posedge clk);
    old_w = mem_m[op.ra];
    mrg   = old_w;
    for (int i = 0; i < 2; i++) begin
      if (op.w && op.wa == op.ra && op.m[i]) mrg[i*8 +: 8] = op.d[i*8 +: 8];
    end
    rd = (RDW_MODE == 1) ? mrg : old_w;
    if (op.r) last_d = rd;
    sb.push_back('{v: op.r, d: last_d});
    if (op.w) begin
      for (int i = 0; i < 2; i++) begin
        if (op.m[i]) mem_m[op.wa][i*8 +: 8] = op.d[i*8 +: 8];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    int   k;
    exp_t e;
    op_t  ops [$];
    set_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.dvalid !== 1'b0 || bus.dout !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state: busy=%b dvalid=%b dout=%h, expected busy=1 dvalid=0 dout=0000",
               bus.busy, bus.dvalid, bus.dout);
    end
    @(negedge clk); rst = 1'b0;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (bus.busy === 1'b1 && k < 300);
    checks++;
    if (k !== 256) begin
      failures++;
      $display("FAIL first_clear_len: busy high for %0d cycles, expected 256", k);
    end
    reset_model();
    for (int a = 0; a < 256; a++) drive('{w: 1'b1, m: 2'b11, wa: 8'(a), d: 16'hA5A5, r: 1'b0, ra: 8'h00});
    @(negedge clk); set_idle(); rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    reset_model();
    k = 0;
    do begin @(posedge clk); #1; k++; end while (bus.busy === 1'b1 && k < 300);
    checks++;
    if (k !== 256) begin
      failures++;
      $display("FAIL clear_len: busy high for %0d cycles, expected 256", k);
    end
    ops.push_back('{w: 1'b0, m: 2'b00, wa: 8'h00, d: 16'h0, r: 1'b1, ra: 8'd0});
    ops.push_back('{w: 1'b0, m: 2'b00, wa: 8'h00, d: 16'h0, r: 1'b1, ra: 8'd127});
    ops.push_back('{w: 1'b0, m: 2'b00, wa: 8'h00, d: 16'h0, r: 1'b1, ra: 8'd255});
    for (int i = 0; i < LAT; i++) ops.push_back('0);
    foreach (ops[i]) begin
      drive(ops[i]);
      if (sb.size() >= LAT) begin
        e = sb.pop_front();
        checks++;
        if (bus.dvalid !== e.v || bus.dout !== e.d) begin
          failures++;
          $display("FAIL clear_read[%0d]: dvalid=%b dout=%h, expected dvalid=%b dout=%h",
                   i, bus.dvalid, bus.dout, e.v, e.d);
        end
      end
    end
  endtask

  task automatic test_mask();
    exp_t e;
    op_t  ops [$];
    sb.delete();
    ops.push_back('{w: 1'b1, m: 2'b11, wa: 8'h10, d: 16'h1234, r: 1'b0, ra: 8'h00});
    ops.push_back('{w: 1'b1, m: 2'b01, wa: 8'h10, d: 16'hFFFF, r: 1'b0, ra: 8'h00});
    ops.push_back('{w: 1'b0, m: 2'b00, wa: 8'h00, d: 16'h0000, r: 1'b1, ra: 8'h10});
    ops.push_back('{w: 1'b1, m: 2'b00, wa: 8'h10, d: 16'h5555, r: 1'b0, ra: 8'h00});
    ops.push_back('{w: 1'b0, m: 2'b00, wa: 8'h00, d: 16'h0000, r: 1'b1, ra: 8'h10});
    for (int i = 0; i < LAT; i++) ops.push_back('0);
    foreach (ops[i]) begin
      drive(ops[i]);
      if (sb.size() >= LAT) begin
        e = sb.pop_front();
        checks++;
        if (bus.dvalid !== e.v || bus.dout !== e.d) begin
          failures++;
          $display("FAIL mask[%0d]: dvalid=%b dout=%h, expected dvalid=%b dout=%h",
                   i, bus.dvalid, bus.dout, e.v, e.d);
        end
      end
    end
  endtask

  task automatic test_rdw();
    exp_t e;
    op_t  ops [$];
    sb.delete();
    ops.push_back('{w: 1'b1, m: 2'b11, wa: 8'h20, d: 16'h0000, r: 1'b0, ra: 8'h00});
    ops.push_back('{w: 1'b1, m: 2'b10, wa: 8'h20, d: 16'hABCD, r: 1'b1, ra: 8'h20});
    ops.push_back('{w: 1'b0, m: 2'b00, wa: 8'h00, d: 16'h0000, r: 1'b1, ra: 8'h20});
    // Different addresses in the same cycle must not interact.
    ops.push_back('{w: 1'b1, m: 2'b11, wa: 8'h30, d: 16'h7E7E, r: 1'b1, ra: 8'h20});
    ops.push_back('{w: 1'b0, m: 2'b00, wa: 8'h00, d: 16'h0000, r: 1'b1, ra: 8'h30});
    for (int i = 0; i < LAT; i++) ops.push_back('0);
    foreach (ops[i]) begin
      drive(ops[i]);
      if (sb.size() >= LAT) begin
        e = sb.pop_front();
        checks++;
        if (bus.dvalid !== e.v || bus.dout !== e.d) begin
          failures++;
          $display("FAIL rdw[%0d]: dvalid=%b dout=%h, expected dvalid=%b dout=%h",
                   i, bus.dvalid, bus.dout, e.v, e.d);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int   k;
    exp_t e;
    op_t  ops [$];
    @(negedge clk); set_idle(); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    reset_model();
    bus.we = 1'b1; bus.wmask = 2'b11; bus.waddr = 8'h05; bus.din = 16'hBEEF;
    bus.re = 1'b1; bus.raddr = 8'h05;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
      if (bus.busy === 1'b1 && (k % 64) == 1) begin
        checks++;
        if (bus.dvalid !== 1'b0 || bus.dout !== 16'h0000) begin
          failures++;
          $display("FAIL busy_outputs: dvalid=%b dout=%h at cycle %0d, expected 0 and 0000",
                   bus.dvalid, bus.dout, k);
        end
      end
    end while (bus.busy === 1'b1 && k < 300);
    set_idle();
    checks++;
    if (k !== 256) begin
      failures++;
      $display("FAIL restart_len: busy high for %0d cycles after second release, expected 256", k);
    end
    ops.push_back('{w: 1'b0, m: 2'b00, wa: 8'h00, d: 16'h0000, r: 1'b1, ra: 8'h05});
    for (int i = 0; i < LAT; i++) ops.push_back('0);
    foreach (ops[i]) begin
      drive(ops[i]);
      if (sb.size() >= LAT) begin
        e = sb.pop_front();
        checks++;
        if (bus.dvalid !== e.v || bus.dout !== e.d) begin
          failures++;
          $display("FAIL dropped_write[%0d]: dvalid=%b dout=%h, expected dvalid=%b dout=%h",
                   i, bus.dvalid, bus.dout, e.v, e.d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    op_t  ops [$];
    sb.delete();
    for (int a = 0; a < 8; a++) begin
      ops.push_back('{w: 1'b1, m: 2'b11, wa: 8'(a), d: 16'(a * 16'h0101), r: 1'b0, ra: 8'h00});
    end
    for (int a = 0; a < 8; a++) begin
      ops.push_back('{w: 1'b0, m: 2'b00, wa: 8'h00, d: 16'h0000, r: 1'b1, ra: 8'(a)});
    end
    for (int i = 0; i < LAT + 2; i++) ops.push_back('0);
    foreach (ops[i]) begin
      drive(ops[i]);
      if (sb.size() >= LAT) begin
        e = sb.pop_front();
        checks++;
        if (bus.dvalid !== e.v || bus.dout !== e.d) begin
          failures++;
          $display("FAIL stream[%0d]: dvalid=%b dout=%h, expected dvalid=%b dout=%h",
                   i, bus.dvalid, bus.dout, e.v, e.d);
        end
      end
    end
  endtask

  initial begin
    set_idle();
    reset_model();
    test_reset();
    test_mask();
    test_rdw();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ramsdp_clr.md
Name: ramsdp_clr

Overview:
- Simple dual-port synchronous RAM: one write port, one read port, both on one clock.
- Successor to the single-port async-read RAM: per-byte write mask, registered read with valid strobe, selectable read-during-write policy.
- Built-in clear engine zeroes the whole array after reset.
- Used as the default scratch/buffer memory in memory-class benchmarks.

Parameters:
- DW, 16, data width in bits; must be an integer multiple of BW.
- AW, 8, address width; depth = 2**AW words.
- BW, 8, bits per write-mask lane; NB = DW/BW lanes.
- RDW_MODE, 0, same-address read-during-write policy: 0 = old data, 1 = new (merged) data.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- busy  out  1  high while the clear engine runs; ports ignored
- we  in  1  write enable
- wmask  in  NB  per-lane write enable, lane i = din[i*BW +: BW]
- waddr  in  AW  write address
- din  in  DW  write data
- re  in  1  read enable
- raddr  in  AW  read address
- dout  out  DW  read data
- dvalid  out  1  dout holds fresh data for a read issued the previous cycle

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- FSM states: CLEAR and READY.
  - Any cycle with rst=1 forces CLEAR, clear counter = 0, busy=1, dvalid=0, dout=0.
  - The array is not written while rst=1.
- CLEAR sweep (rst=0):
  - Each cycle writes all-zero to mem[cnt] and increments cnt.
  - After writing address 2**AW-1, next state is READY.
  - busy falls on the edge after the last clear write: exactly 2**AW cycles after the first rst=0 edge.
  - Counter is AW+1 bits, or terminal detect on all-ones; no wrap back into the sweep.
- Reset mid-sweep: the sweep restarts from address 0 and the full 2**AW cycles follow.
- While busy=1:
  - we, re, wmask, din and the addresses are ignored.
  - dvalid=0; dout holds 0.
- Write (READY): if we=1, for each lane i with wmask[i]=1, mem[waddr] lane i <= din lane i.
  - Lanes with wmask[i]=0 are unchanged.
  - we=1 with wmask=0 is a legal no-op.
- Read (READY), latency 1:
  - re=1 at edge n: dout = mem[raddr] and dvalid=1 after edge n.
  - re=0: dvalid=0 next cycle; dout holds its last value.
- Back-to-back reads: every cycle is legal, throughput 1 word/cycle.
- Same address with we=1 and re=1 in the same cycle:
  - RDW_MODE=0: dout = word before the write.
  - RDW_MODE=1: dout = merged word; masked lanes from din, other lanes from the old contents.
- Different addresses with we=1 and re=1: independent, no interaction.
- Write to address X at cycle n, read of X at cycle n+1: returns the written data in both modes.
- Addresses are full-range: no out-of-range case, no wrap logic.

Optional Feature:
- Macro: RAMSDP_CLR_OUTREG_EN.
- Defined:
  - An extra output pipeline stage; read latency 2 (re at edge n -> dout/dvalid after edge n+1).
  - Both stages reset to 0 with rst; the extra stage's valid is forced 0 while busy=1.
  - RDW behaviour is unchanged, only delayed one cycle.
- Undefined: latency 1 as above; no extra flops.

Test Plan:
1. Preload every address with 0xA5A5, assert rst 3 cycles, release, wait:
   - busy=1 for exactly 256 cycles after release, then 0.
   - Reads of addresses 0, 127, 255 return 0x0000 with dvalid=1 one cycle after re.
2. After clear, we=1, waddr=0x10, din=0x1234, wmask=2'b11; next write din=0xFFFF, wmask=2'b01; then re raddr=0x10:
   - dout=0x12FF, dvalid=1 one cycle after re.
3. mem[0x20]=0x0000; same cycle we=1, wmask=2'b10, waddr=raddr=0x20, din=0xABCD, re=1:
   - RDW_MODE=0 -> dout=0x0000.
   - RDW_MODE=1 -> dout=0xAB00.
   - A read of 0x20 the next cycle returns 0xAB00 in both modes.
4. Assert rst at sweep cycle 100 for 1 cycle:
   - busy stays 1 and falls exactly 256 cycles after the second release.
   - A we=1, waddr=0x05 issued during busy is dropped: mem[0x05] reads 0.
5. Stream re=1 over raddr 0..7 on consecutive cycles after writing data=addr*0x0101:
   - dvalid=1 for 8 consecutive cycles, dout sequence 0x0000..0x0707.
   - dvalid=0 the cycle after re drops; dout holds 0x0707.
6. Repeat tests 2 and 5 with RAMSDP_CLR_OUTREG_EN defined: identical data, each response one cycle later.
